// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the sequential 4-bit divider/multiplier.
package muldiv_pkg;

    localparam int WIDTH = 4;
    localparam int ITER  = 4;

    localparam logic OP_DIV = 1'b0;
    localparam logic OP_MUL = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/adder_cum_subtractor4b.sv
// 4-bit ripple adder/subtractor: i_cin=1 inverts i_y and adds one, giving i_x - i_y.
module adder_cum_subtractor4b (
    input  logic [3:0] i_x,
    input  logic [3:0] i_y,
    input  logic       i_cin,
    output logic [3:0] o_s,
    output logic       o_cout
);

    logic [3:0] w_y;

    assign w_y           = i_y ^ {4{i_cin}};
    assign {o_cout, o_s} = {1'b0, i_x} + {1'b0, w_y} + {4'b0000, i_cin};

endmodule

// File: rtl/seq_muldiv4b.sv
// Sequential 4-bit unsigned restoring divider; multiply (shift-add) mode is
// added when MULDIV_MULT_EN is defined.
module seq_muldiv4b
    import muldiv_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             dbz
);

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_q, r_m;
    logic [1:0]       r_cnt;
    logic             r_dbz;

    logic [WIDTH-1:0] w_ashift, w_x, w_s, w_a_div;
    logic             w_cin, w_cout, w_qbit, w_dbz_in, w_mul;

    // Divide: {A,Q} shifted left; the bit leaving A covers the 5th bit of the partial remainder.
    assign w_ashift = {r_a[WIDTH-2:0], r_q[WIDTH-1]};
    assign w_qbit   = r_a[WIDTH-1] | w_cout;
    assign w_a_div  = w_qbit ? w_s : w_ashift;

`ifdef MULDIV_MULT_EN
    logic             r_c, r_op;
    logic             w_c_n;
    logic [WIDTH-1:0] w_a_n;

    assign w_mul    = (r_op == OP_MUL);
    assign w_x      = w_mul ? r_a : w_ashift;
    assign w_cin    = ~w_mul;
    assign w_dbz_in = (op == OP_DIV) && (opb == '0);
    assign w_c_n    = r_q[0] ? w_cout : r_c;
    assign w_a_n    = r_q[0] ? w_s : r_a;
`else
    logic w_unused_op;

    assign w_unused_op = op;
    assign w_mul       = 1'b0;
    assign w_x         = w_ashift;
    assign w_cin       = 1'b1;
    assign w_dbz_in    = (opb == '0);
`endif

    adder_cum_subtractor4b u_addsub (
        .i_x    (w_x),
        .i_y    (r_m),
        .i_cin  (w_cin),
        .o_s    (w_s),
        .o_cout (w_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = RUN;
            end
            RUN:  if (r_cnt == 2'(ITER - 1)) w_next = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_q   <= '0;
            r_m   <= '0;
            r_cnt <= '0;
            r_dbz <= 1'b0;
`ifdef MULDIV_MULT_EN
            r_c   <= 1'b0;
            r_op  <= OP_DIV;
`endif
        end else if (r_state == IDLE && in_valid) begin
            r_a   <= '0;
            r_q   <= opa;
            r_m   <= opb;
            r_cnt <= '0;
            r_dbz <= w_dbz_in;
`ifdef MULDIV_MULT_EN
            r_c   <= 1'b0;
            r_op  <= op;
`endif
        end else if (r_state == RUN) begin
            r_cnt <= r_cnt + 2'd1;
`ifdef MULDIV_MULT_EN
            r_c   <= 1'b0;
`endif
            if (!w_mul) begin
                r_a <= w_a_div;
                r_q <= {r_q[WIDTH-2:0], w_qbit};
            end
`ifdef MULDIV_MULT_EN
            else begin
                // Right shift of {C,A,Q} after the conditional add; C refills with 0.
                r_a <= {w_c_n, w_a_n[WIDTH-1:1]};
                r_q <= {w_a_n[0], r_q[WIDTH-1:1]};
            end
`endif
        end
    end

    assign res_hi = r_a;
    assign res_lo = r_q;
    assign dbz    = r_dbz;

endmodule

// File: tb/tb_seq_muldiv4b.sv
// Directed self-checking bench for seq_muldiv4b; multiply vectors run when MULDIV_MULT_EN is defined.
module tb_seq_muldiv4b;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic       op;
    logic [3:0] opa;
    logic [3:0] opb;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] res_hi;
    logic [3:0] res_lo;
    logic       dbz;

    int total = 0;
    int bad   = 0;

    seq_muldiv4b dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .opa       (opa),
        .opb       (opb),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res_hi    (res_hi),
        .res_lo    (res_lo),
        .dbz       (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic o, input logic [3:0] a, input logic [3:0] b);
        op       = o;
        opa      = a;
        opb      = b;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 12) begin
            step();
            n++;
        end
        chk({tag, "_latency"}, 8'(n), 8'd4);
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_in_ready_after"}, {7'd0, in_ready}, 8'd1);
        chk({tag, "_out_valid_after"}, {7'd0, out_valid}, 8'd0);
    endtask

    task automatic run_op(input string tag, input logic o, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] e_hi, input logic [3:0] e_lo, input logic e_dbz);
        start(o, a, b);
        chk({tag, "_busy"}, {7'd0, in_ready}, 8'd0);
        wait_done(tag);
        chk({tag, "_hi"}, {4'd0, res_hi}, {4'd0, e_hi});
        chk({tag, "_lo"}, {4'd0, res_lo}, {4'd0, e_lo});
        chk({tag, "_dbz"}, {7'd0, dbz}, {7'd0, e_dbz});
        release_result(tag);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 1'b0;
        opa       = 4'd0;
        opb       = 4'd0;
        #12;
        chk("rst_in_ready", {7'd0, in_ready}, 8'd1);
        chk("rst_out_valid", {7'd0, out_valid}, 8'd0);
        chk("rst_res", {res_hi, res_lo}, 8'h00);
        chk("rst_dbz", {7'd0, dbz}, 8'd0);
        rst_n = 1'b1;
        step();

        run_op("div13_3", 1'b0, 4'd13, 4'd3, 4'd1, 4'd4, 1'b0);
        run_op("div15_1", 1'b0, 4'd15, 4'd1, 4'd0, 4'd15, 1'b0);
        run_op("div2_9", 1'b0, 4'd2, 4'd9, 4'd2, 4'd0, 1'b0);
        run_op("div7_0", 1'b0, 4'd7, 4'd0, 4'd7, 4'hF, 1'b1);
        run_op("div15_15", 1'b0, 4'd15, 4'd15, 4'd0, 4'd1, 1'b0);

`ifdef MULDIV_MULT_EN
        run_op("mul15_15", 1'b1, 4'd15, 4'd15, 4'hE, 4'h1, 1'b0);
        run_op("mul0_9", 1'b1, 4'd0, 4'd9, 4'h0, 4'h0, 1'b0);
        run_op("mul6_5", 1'b1, 4'd6, 4'd5, 4'h1, 4'hE, 1'b0);
        run_op("mul_b0", 1'b1, 4'd7, 4'd0, 4'h0, 4'h0, 1'b0);
`endif

        // Backpressure: results must hold and new operands must be ignored.
        start(1'b0, 4'd11, 4'd4);
        wait_done("hold");
        op       = 1'b0;
        opa      = 4'd1;
        opb      = 4'd1;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hold_res", {res_hi, res_lo}, 8'h32);
            chk("hold_in_ready", {7'd0, in_ready}, 8'd0);
            chk("hold_out_valid", {7'd0, out_valid}, 8'd1);
        end
        in_valid = 1'b0;
        release_result("hold");

        // Asynchronous abort mid-operation.
        start(1'b0, 4'd13, 4'd3);
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("abort_res", {res_hi, res_lo}, 8'h00);
        chk("abort_in_ready", {7'd0, in_ready}, 8'd1);
        chk("abort_out_valid", {7'd0, out_valid}, 8'd0);
        step();
        rst_n = 1'b1;
        step();
        run_op("div9_2", 1'b0, 4'd9, 4'd2, 4'd1, 4'd4, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
